// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction fetch queue.
package fetch_pkg;

   localparam int ADDR_W_DEF   = 16;
   localparam int DATA_W_DEF   = 16;
   localparam int RESET_PC_DEF = 0;
   localparam int INC_DEF      = 2;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      HALT
   } state_e;

   // Queue entry at the default widths; the top re-declares it at its own widths.
   typedef struct packed {
      logic [DATA_W_DEF-1:0] instr;
      logic [ADDR_W_DEF-1:0] pc;
      logic [ADDR_W_DEF-1:0] pc_next;
   } fq_entry_t;

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Fetch-unit bus: control inputs, instruction-memory port and decode handshake.
interface fetch_queue_unit_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              halt_req;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_stall;
   logic              imem_rsp_valid;
   logic [DATA_W-1:0] imem_rsp_data;
   logic              if_valid;
   logic [DATA_W-1:0] if_instr;
   logic [ADDR_W-1:0] if_pc;
   logic [ADDR_W-1:0] if_pc_next;
   logic              id_ready;
   logic              halted;

   modport master (
      input  redirect_valid, redirect_pc, halt_req, imem_stall,
             imem_rsp_valid, imem_rsp_data, id_ready,
      output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_next, halted
   );

   modport slave (
      output redirect_valid, redirect_pc, halt_req, imem_stall,
             imem_rsp_valid, imem_rsp_data, id_ready,
      input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_next, halted
   );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; storage is not reset, only pointers and count.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       din,
   input  logic                   pop,
   input  logic                   flush,
   output logic [WIDTH-1:0]       dout,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             full, do_push, do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   // A push into a full FIFO is legal when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem_q[rd_q];
   assign count   = cnt_q;

   always_comb begin
      mem_d = mem_q;
      rd_d  = rd_q + PTR_W'(do_pop);
      wr_d  = wr_q + PTR_W'(do_push);
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
      if (do_push) mem_d[wr_q] = din;
      if (flush) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: PC, credit-limited memory requests, instruction queue, redirect/halt.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_queue_unit
   import fetch_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int DEPTH    = 4,
   parameter int RESET_PC = RESET_PC_DEF,
   parameter int INC      = INC_DEF
) (
   input logic                clk,
   input logic                rst,
   fetch_queue_unit_if.master bus
);
   localparam int CNT_W  = $clog2(DEPTH) + 1;
   localparam int USED_W = CNT_W + 1;
   localparam logic [ADDR_W-1:0] INC_A    = ADDR_W'(INC);
   localparam logic [ADDR_W-1:0] RST_PC_A = ADDR_W'(RESET_PC);

   typedef struct packed {
      logic [DATA_W-1:0] instr;
      logic [ADDR_W-1:0] pc;
      logic [ADDR_W-1:0] pc_next;
   } entry_t;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]  out_q, out_d, drop_q, drop_d;
   logic [CNT_W-1:0]  q_count, tag_count;
   logic              q_empty, tag_empty;
   logic [ADDR_W-1:0] tag_head;
   entry_t            q_din, q_dout, head;
   logic [USED_W-1:0] used;
   logic              req, accept, rsp_live, rsp_drop, byp_valid, q_push, q_pop, if_valid;

   // Queued plus in-flight entries never exceed DEPTH, so the queue cannot overflow.
   assign used     = USED_W'(q_count) + USED_W'(out_q);
   assign req      = !rst && (state_q == RUN) && (used < USED_W'(DEPTH)) && !bus.redirect_valid;
   assign accept   = req && !bus.imem_stall;
   assign rsp_live = bus.imem_rsp_valid && (drop_q == '0) && !tag_empty;
   assign rsp_drop = bus.imem_rsp_valid && (drop_q != '0);

   assign q_din = '{instr: bus.imem_rsp_data, pc: tag_head, pc_next: tag_head + INC_A};

`ifdef FETCH_BYPASS_EN
   assign byp_valid = q_empty && rsp_live;
`else
   assign byp_valid = 1'b0;
`endif

   assign q_push   = rsp_live && !(byp_valid && bus.id_ready);
   assign q_pop    = bus.id_ready && !q_empty;
   assign head     = q_empty ? q_din : q_dout;
   assign if_valid = !q_empty || byp_valid;

   assign bus.imem_req   = req;
   assign bus.imem_addr  = pc_q;
   assign bus.if_valid   = if_valid;
   assign bus.if_instr   = if_valid ? head.instr : '0;
   assign bus.if_pc      = if_valid ? head.pc : '0;
   assign bus.if_pc_next = if_valid ? head.pc_next : '0;
   assign bus.halted     = (state_q == HALT);

   sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag_fifo (
      .clk(clk), .rst(rst), .push(accept), .din(pc_q), .pop(rsp_live),
      .flush(bus.redirect_valid), .dout(tag_head), .count(tag_count), .empty(tag_empty)
   );

   sync_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_instr_q (
      .clk(clk), .rst(rst), .push(q_push), .din(q_din), .pop(q_pop),
      .flush(bus.redirect_valid), .dout(q_dout), .count(q_count), .empty(q_empty)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      out_d   = out_q + CNT_W'(accept) - CNT_W'(rsp_live);
      drop_d  = drop_q;
      if (accept) pc_d = pc_q + INC_A;
      if (rsp_drop) drop_d = drop_q - CNT_W'(1);
      case (state_q)
         RUN:     if (bus.halt_req) state_d = HALT;
         DRAIN:   if (drop_d == '0) state_d = RUN;
         default: state_d = state_q;
      endcase
      // Every in-flight fetch becomes stale; a response landing this cycle is one of them.
      if (bus.redirect_valid) begin
         pc_d    = bus.redirect_pc;
         drop_d  = drop_q + out_q - CNT_W'(rsp_live || rsp_drop);
         out_d   = '0;
         state_d = (out_q == '0) ? RUN : DRAIN;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         pc_q    <= RST_PC_A;
         out_q   <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         out_q   <= out_d;
         drop_q  <= drop_d;
      end
   end

   // A response with nothing outstanding and nothing to drop is ignored by the datapath.
   a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
      bus.imem_rsp_valid |-> (drop_q != '0 || !tag_empty));
   a_tag_tracks_out: assert property (@(posedge clk) disable iff (rst) tag_count == out_q);
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit with an in-order, fixed-latency instruction memory model.
module tb_fetch_queue_unit;
   localparam int AW    = 16;
   localparam int DW    = 16;
   localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   fetch_queue_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   fetch_queue_unit #(
      .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(0), .INC(2)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus.master)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      int            due;
   } mreq_t;

   mreq_t         mq[$];
   logic [AW-1:0] got_pc[$];
   logic [AW-1:0] got_nx[$];
   logic [DW-1:0] got_in[$];
   int            n_tests = 0;
   int            n_fail  = 0;
   int            cyc     = 0;
   int            lat     = 1;
   int            n_acc   = 0;
   int            n_deq   = 0;
   logic [AW-1:0] exp_pc  = '0;
   logic [AW-1:0] last_pc = '0;

   function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
      return a ^ 16'hC3A5;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive_rsp();
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = mdata(mq[0].addr);
      end else begin
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data  = '0;
      end
   endtask

   // One clock: sample handshakes before the edge, advance the memory model after it.
   task automatic tick();
      logic          acc, rt;
      logic [AW-1:0] a;
      #2;
      acc = bus.imem_req && !bus.imem_stall;
      a   = bus.imem_addr;
      rt  = bus.imem_rsp_valid;
      if (bus.if_valid && bus.id_ready && !bus.redirect_valid) begin
         got_pc.push_back(bus.if_pc);
         got_nx.push_back(bus.if_pc_next);
         got_in.push_back(bus.if_instr);
         n_deq++;
      end
      if (acc) n_acc++;
      @(posedge clk);
      #1;
      cyc++;
      if (rt) void'(mq.pop_front());
      if (acc) mq.push_back('{addr: a, due: cyc + lat - 1});
      drive_rsp();
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check_stream(input string tag);
      logic [AW-1:0] p, nx, ins, enx;
      while (got_pc.size() > 0) begin
         p   = got_pc.pop_front();
         nx  = got_nx.pop_front();
         ins = got_in.pop_front();
         enx = exp_pc + 16'd2;
         chk({tag, "_pc"}, p, exp_pc);
         chk({tag, "_pc_next"}, nx, enx);
         chk({tag, "_instr"}, ins, mdata(exp_pc));
         last_pc = p;
         exp_pc  = enx;
      end
   endtask

   task automatic redirect_to(input logic [AW-1:0] pc);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = pc;
      tick();
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int guard;
      int acc0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.halt_req       = 1'b0;
      bus.imem_stall     = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.id_ready       = 1'b1;

      // Reset values
      @(posedge clk);
      @(posedge clk);
      #2;
      chk("rst_req", bus.imem_req, 0);
      chk("rst_addr", bus.imem_addr, 16'h0000);
      chk("rst_valid", bus.if_valid, 0);
      chk("rst_halted", bus.halted, 0);
      chk("rst_instr", bus.if_instr, 0);
      chk("rst_pc_next", bus.if_pc_next, 0);
      rst = 1'b0;
      #1;

      // Streaming with L=1, no stall
      chk("a_c1_req", bus.imem_req, 1);
      chk("a_c1_addr", bus.imem_addr, 16'h0000);
      chk("a_c1_valid", bus.if_valid, 0);
      tick();
      chk("a_c2_valid", bus.if_valid, BYP);
      tick();
      chk("a_c3_valid", bus.if_valid, 1);
      chk("a_c3_pc", bus.if_pc, BYP ? 16'h0002 : 16'h0000);
      ticks(3);
      chk("a_deliv", got_pc.size() >= 3, 1);
      check_stream("a");

      // Stall at 0x0010
      guard = 0;
      while (bus.imem_addr !== 16'h0010 && guard < 20) begin
         tick();
         guard++;
      end
      chk("b_reach_10", bus.imem_addr, 16'h0010);
      bus.imem_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("b_stall_addr", bus.imem_addr, 16'h0010);
      end
      bus.imem_stall = 1'b0;
      tick();
      chk("b_resume_addr", bus.imem_addr, 16'h0012);
      ticks(6);
      check_stream("b");

      // Decode back-pressure fills the queue
      bus.id_ready = 1'b0;
      ticks(10);
      chk("c_req_off", bus.imem_req, 0);
      chk("c_valid", bus.if_valid, 1);
      chk("c_fill", n_acc - n_deq, DEPTH);
      check_stream("c0");
      chk("c_head_pc", bus.if_pc, exp_pc);
      bus.id_ready = 1'b1;
      ticks(12);
      check_stream("c");

      // Redirect with three fetches in flight at L=3
      bus.imem_stall = 1'b1;
      ticks(6);
      lat = 3;
      check_stream("d0");
      chk("d_drained", bus.if_valid, 0);
      bus.imem_stall = 1'b0;
      #1;
      ticks(3);
      chk("d_req_before", bus.imem_req, 1);
      redirect_to(16'h0100);
      chk("d_halted", bus.halted, 0);
      chk("d_drain_req0", bus.imem_req, 0);
      chk("d_flushed", bus.if_valid, 0);
      tick();
      chk("d_drain_req1", bus.imem_req, 0);
      tick();
      chk("d_run_req", bus.imem_req, 1);
      chk("d_run_addr", bus.imem_addr, 16'h0100);
      exp_pc = 16'h0100;
      ticks(10);
      chk("d_deliv", got_pc.size() != 0, 1);
      check_stream("d");

      // Halt at 0x0020, then redirect to 0x0040
      lat = 1;
      check_stream("e0");
      redirect_to(16'h0018);
      exp_pc = 16'h0018;
      guard = 0;
      while (!(bus.imem_addr === 16'h0020 && bus.imem_req === 1'b1) && guard < 30) begin
         tick();
         guard++;
      end
      chk("e_reach_20", bus.imem_addr, 16'h0020);
      bus.halt_req = 1'b1;
      tick();
      bus.halt_req = 1'b0;
      #1;
      acc0 = n_acc;
      chk("e_halted", bus.halted, 1);
      chk("e_req_off", bus.imem_req, 0);
      ticks(5);
      chk("e_no_new_req", n_acc - acc0, 0);
      chk("e_still_halted", bus.halted, 1);
      check_stream("e");
      chk("e_last_pc", last_pc, 16'h0020);
      chk("e_drained", bus.if_valid, 0);
      redirect_to(16'h0040);
      chk("e_resume", bus.halted, 0);
      chk("e_resume_req", bus.imem_req, 1);
      chk("e_resume_addr", bus.imem_addr, 16'h0040);
      exp_pc = 16'h0040;
      ticks(6);
      chk("e_deliv", got_pc.size() != 0, 1);
      check_stream("e2");

      // PC wrap at 0xFFFE and response-cycle visibility
      bus.imem_stall = 1'b1;
      ticks(4);
      check_stream("f0");
      redirect_to(16'hFFFE);
      exp_pc = 16'hFFFE;
      chk("f_addr", bus.imem_addr, 16'hFFFE);
      bus.imem_stall = 1'b0;
      tick();
      bus.imem_stall = 1'b1;
      #1;
      chk("f_wrap_addr", bus.imem_addr, 16'h0000);
      chk("f_rsp_valid", bus.if_valid, BYP);
      chk("f_rsp_pc", bus.if_pc, BYP ? 16'hFFFE : 16'h0000);
      chk("f_rsp_instr", bus.if_instr, BYP ? mdata(16'hFFFE) : 16'h0000);
      tick();
      chk("f_q_valid", bus.if_valid, BYP ? 1'b0 : 1'b1);
      chk("f_q_pc", bus.if_pc, BYP ? 16'h0000 : 16'hFFFE);
      chk("f_q_pc_next", bus.if_pc_next, 16'h0000);
      bus.imem_stall = 1'b0;
      ticks(6);
      chk("f_deliv", got_pc.size() >= 3, 1);
      check_stream("f");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
